// File: rtl/sfu_pkg.sv
// rtl/sfu_pkg.sv - shared fp16 field constants and NaN/Inf classifier for the SFU datapath
package sfu_pkg;

  localparam int         FP16_W        = 16;
  localparam int         FP16_EXP_MSB  = 14;
  localparam int         FP16_EXP_LSB  = 10;
  localparam logic [4:0] FP16_EXP_ONES = 5'h1F;

  // All-ones exponent covers both infinities and every NaN encoding.
  function automatic logic is_nan_inf(input logic [FP16_W-1:0] fp16);
    return fp16[FP16_EXP_MSB:FP16_EXP_LSB] == FP16_EXP_ONES;
  endfunction

endpackage

// File: rtl/sfu_collector_bank.sv
// rtl/sfu_collector_bank.sv - one ping-pong bank: N lanes, full flag, NaN/Inf flag
// NaN/Inf tracking is built only when SFU_COLLECTOR_ERR_EN is defined.
module sfu_collector_bank
  import sfu_pkg::*;
#(
  parameter  int N  = 16,
  parameter  int W  = 16,
  localparam int LW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [LW-1:0] wr_lane,
  input  logic [W-1:0]  wr_data,
  input  logic          pop,
  output logic [N*W-1:0] data_flat,
  output logic          full,
  output logic          err
);

  logic [W-1:0] data [N];

  // Writes only target a non-full bank and pops only a full one, so the two never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) data[i] <= '0;
      full <= 1'b0;
    end else begin
      if (wr_en) data[wr_lane] <= wr_data;
      if (pop) full <= 1'b0;
      else if (wr_en && wr_lane == LW'(N - 1)) full <= 1'b1;
    end
  end

`ifdef SFU_COLLECTOR_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else if (pop) err <= 1'b0;
    else if (wr_en && is_nan_inf(wr_data[FP16_W-1:0])) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign data_flat[i*W +: W] = data[i];
  end

endmodule

// File: rtl/sfu_collector.sv
// rtl/sfu_collector.sv - serial fp16 to N-lane packed vector collector, ping-pong banked
// Optional NaN/Inf flagging via SFU_COLLECTOR_ERR_EN.
module sfu_collector
  import sfu_pkg::*;
#(
  parameter int N = 16,
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [N*W-1:0] out_flat,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_err
);

  localparam int LW = $clog2(N);

  logic [LW-1:0]  wr_ptr;
  logic           wr_bank;
  logic           rd_bank;
  logic [1:0]     full;
  logic [1:0]     err;
  logic [N*W-1:0] flat [2];
  logic           push;
  logic           take;

  // Handshake readiness depends on registered flags only.
  assign in_ready  = !full[wr_bank];
  assign out_valid = full[rd_bank];
  assign push      = in_valid && in_ready;
  assign take      = out_valid && out_ready;
  assign out_flat  = flat[rd_bank];
  assign out_err   = err[rd_bank];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    sfu_collector_bank #(.N(N), .W(W)) u_bank (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (push && wr_bank == 1'(b)),
      .wr_lane  (wr_ptr),
      .wr_data  (in_data),
      .pop      (take && rd_bank == 1'(b)),
      .data_flat(flat[b]),
      .full     (full[b]),
      .err      (err[b])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
    end else begin
      if (push) begin
        if (wr_ptr == LW'(N - 1)) begin
          wr_ptr  <= '0;
          wr_bank <= !wr_bank;
        end else begin
          wr_ptr <= wr_ptr + 1'b1;
        end
      end
      if (take) rd_bank <= !rd_bank;
    end
  end

endmodule
